// File: rtl/gray_conv_pkg.sv
// Shared types and helpers for the Gray-conversion arbiter.
// Gray conversion is done at a fixed maximum width; callers narrow it with a wrapper.
package gray_conv_pkg;

   localparam int unsigned GC_MAX_W = 64;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   // Zero-extended input keeps the MSB rule intact: g[msb] = b[msb] ^ 0.
   function automatic logic [GC_MAX_W-1:0] bin2gray(input logic [GC_MAX_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic int unsigned id_width(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/gray_conv_arbiter_rr_arbiter_core.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter_core
   import gray_conv_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic               any_grant,
   output logic [ID_W-1:0]    idx
);

   logic [ID_W-1:0] cand;

   always_comb begin
      grant     = '0;
      any_grant = 1'b0;
      idx       = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((32'(ptr) + k) % NUM_REQ);
         if (!any_grant && req[cand]) begin
            any_grant = 1'b1;
            idx       = cand;
         end
      end
      if (any_grant) begin
         grant[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin shared binary-to-Gray converter with a registered single-entry
// output stage; drain and reload may happen in the same cycle.
module gray_conv_arbiter
   import gray_conv_pkg::*;
#(
   parameter  int unsigned WIDTH   = 6,
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_gray,
   output logic [WIDTH-1:0]           out_bin,
   output logic [ID_W-1:0]            out_id
);

   function automatic logic [WIDTH-1:0] gray_w(input logic [WIDTH-1:0] b);
      return WIDTH'(bin2gray(GC_MAX_W'(b)));
   endfunction

   state_t               state;
   logic [ID_W-1:0]      rr_ptr;
   logic [NUM_REQ-1:0]   grant;
   logic                 any_grant;
   logic [ID_W-1:0]      win_idx;
   logic [ID_W-1:0]      next_ptr;
   logic [WIDTH-1:0]     sel_bin;
   logic                 can_load;
   logic                 load;

   rr_arbiter_core #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .any_grant (any_grant),
      .idx       (win_idx)
   );

   assign can_load  = (state == EMPTY) || (out_ready && out_valid);
   assign load      = can_load && any_grant;
   // Grants are suppressed while in reset so no requester sees a phantom accept.
   assign req_ready = (rst_n && load) ? grant : '0;
   assign next_ptr  = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(win_idx + 1'b1);

   always_comb begin
      sel_bin = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_bin = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Output stage FSM: EMPTY <-> FULL, pointer advances only on a handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         out_gray  <= '0;
         out_bin   <= '0;
         out_id    <= '0;
         rr_ptr    <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (load) begin
                  state     <= FULL;
                  out_valid <= 1'b1;
                  out_bin   <= sel_bin;
                  out_gray  <= gray_w(sel_bin);
                  out_id    <= win_idx;
                  rr_ptr    <= next_ptr;
               end
            end
            FULL: begin
               if (load) begin
                  out_bin   <= sel_bin;
                  out_gray  <= gray_w(sel_bin);
                  out_id    <= win_idx;
                  rr_ptr    <= next_ptr;
               end else if (out_ready) begin
                  state     <= EMPTY;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= EMPTY;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench for gray_conv_arbiter: directed scenarios plus random traffic.
module tb_gray_conv_arbiter;

   localparam int unsigned WIDTH   = 6;
   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned ID_W    = 2;
   localparam int unsigned DW      = NUM_REQ * WIDTH;

   typedef struct {
      logic [WIDTH-1:0] bin;
      logic [WIDTH-1:0] gray;
      int               id;
   } exp_t;

   logic                 clk;
   logic                 rst_n;
   logic [NUM_REQ-1:0]   req_valid;
   logic [DW-1:0]        req_data;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     out_gray;
   logic [WIDTH-1:0]     out_bin;
   logic [ID_W-1:0]      out_id;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   m_ptr = 0;
   bit   m_full = 0;

   gray_conv_arbiter #(
      .WIDTH   (WIDTH),
      .NUM_REQ (NUM_REQ)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_gray  (out_gray),
      .out_bin   (out_bin),
      .out_id    (out_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] ref_gray(input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] g;
      g[WIDTH-1] = b[WIDTH-1];
      for (int k = 0; k < WIDTH - 1; k++) g[k] = b[k+1] ^ b[k];
      return g;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] slot(input int i, input logic [WIDTH-1:0] v);
      logic [DW-1:0] d;
      d = '0;
      d[i*WIDTH +: WIDTH] = v;
      return d;
   endfunction

   // One clock of stimulus; called just after a rising edge, returns just after the next.
   task automatic step(input logic [NUM_REQ-1:0] v, input logic [DW-1:0] d, input logic rdy);
      int               winner;
      bit               hs;
      logic [NUM_REQ-1:0] exp_ready;
      exp_t             e;
      req_valid = v;
      req_data  = d;
      out_ready = rdy;
      winner    = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
         int i;
         i = (m_ptr + k) % NUM_REQ;
         if (winner < 0 && v[i]) winner = i;
      end
      hs        = (winner >= 0) && (!m_full || rdy);
      exp_ready = '0;
      if (hs) exp_ready[winner] = 1'b1;
      #1;
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      if (hs) begin
         e.bin  = d[winner*WIDTH +: WIDTH];
         e.gray = ref_gray(e.bin);
         e.id   = winner;
         sb.push_back(e);
      end
      @(posedge clk);
      if (hs) begin
         m_full = 1'b1;
         m_ptr  = (winner + 1) % NUM_REQ;
      end else if (m_full && rdy) begin
         m_full = 1'b0;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_req_ready", 64'(req_ready), 64'(0));
      check("rst_out_gray", 64'(out_gray), 64'(0));
      check("rst_out_bin", 64'(out_bin), 64'(0));
      check("rst_out_id", 64'(out_id), 64'(0));
      sb.delete();
      m_full = 1'b0;
      m_ptr  = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: compares the presented output with the scoreboard head.
   always @(negedge clk) begin
      if (rst_n) begin
         check("out_valid", 64'(out_valid), 64'(m_full));
         if (out_valid) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL sb_empty: output id %0d with no expected entry", out_id);
            end else begin
               check("out_bin", 64'(out_bin), 64'(sb[0].bin));
               check("out_gray", 64'(out_gray), 64'(sb[0].gray));
               check("out_id", 64'(out_id), 64'(sb[0].id));
               if (out_ready) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = '1;
      req_data  = '0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Single request from requester 2.
      step(4'b0100, slot(2, 6'd45), 1'b1);
      check("single_valid", 64'(out_valid), 64'(1));
      check("single_bin", 64'(out_bin), 64'(45));
      check("single_gray", 64'(out_gray), 64'h3B);
      check("single_id", 64'(out_id), 64'(2));

      // Round-robin with everyone valid.
      do_reset();
      for (int k = 0; k < 8; k++) begin
         step(4'b1111, DW'($urandom), 1'b1);
         check("rr_id", 64'(out_id), 64'(k % NUM_REQ));
      end

      // Back-pressure with 63 held from requester 1.
      do_reset();
      step(4'b0010, slot(1, 6'd63), 1'b1);
      for (int k = 0; k < 5; k++) begin
         step(4'b1111, DW'($urandom), 1'b0);
         check("bp_gray", 64'(out_gray), 64'h20);
         check("bp_id", 64'(out_id), 64'(1));
      end
      step(4'b1111, DW'($urandom), 1'b1);
      check("bp_reload_id", 64'(out_id), 64'(2));

      // Pointer wrap: serve 3, then only 0 and 3 alternate.
      do_reset();
      step(4'b1000, DW'($urandom), 1'b1);
      for (int k = 0; k < 4; k++) begin
         step(4'b1001, DW'($urandom), 1'b1);
         check("wrap_id", 64'(out_id), (k % 2 == 0) ? 64'(0) : 64'(3));
      end

      // Idle drain keeps the pointer.
      step(4'b0010, slot(1, 6'd7), 1'b1);
      step(4'b0000, '0, 1'b1);
      check("idle_drop", 64'(out_valid), 64'(0));
      repeat (3) step(4'b0000, '0, 1'b1);
      step(4'b1111, DW'($urandom), 1'b1);
      check("idle_next_id", 64'(out_id), 64'(2));

      // Reset while full and stalled.
      step(4'b1111, DW'($urandom), 1'b0);
      step(4'b1111, DW'($urandom), 1'b0);
      do_reset();
      step(4'b1111, DW'($urandom), 1'b1);
      check("post_rst_id", 64'(out_id), 64'(0));

      // Random traffic.
      for (int k = 0; k < 400; k++) begin
         step(NUM_REQ'($urandom), DW'($urandom), ($urandom_range(3, 0) != 0));
      end

      repeat (3) step(4'b0000, '0, 1'b1);
      check("sb_drained", 64'(sb.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
